// File: rtl/uart_mike_rx_fifo.sv
// UART receiver (configurable data/parity/stop/baud) feeding a first-word-fall-through frame FIFO.
// Sticky parity/frame/overrun flags; break detection is built when UART_MIKE_RX_BREAK_DET_EN is defined.
module uart_mike_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_error,
  output logic                            frame_error,
  output logic                            overrun,
  input  logic                            err_clr,
  output logic                            break_det
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
`ifdef UART_MIKE_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DAT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_mis_q, par_mis_d;
  logic                    fault_q, fault_d;
  logic                    zero_q, zero_d;
  logic                    armed_q, armed_d;
  logic                    rx_meta_q, rx_s_q;
  logic [1:0]              warm_q;
  logic                    push, set_pe, set_fe, brk;
  logic                    frame_bad;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    pe_q, fe_q, ovr_q, brk_q;
  logic                    pop, full, do_push, drop;

  // warm_q keeps the reset value of the synchroniser from arming the receiver
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      warm_q    <= 2'b00;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      warm_q    <= {warm_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_mis_q <= 1'b0;
      fault_q   <= 1'b0;
      zero_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_mis_q <= par_mis_d;
      fault_q   <= fault_d;
      zero_q    <= zero_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_mis_d = par_mis_q;
    fault_d   = fault_q;
    zero_d    = zero_q;
    armed_d   = armed_q;
    push      = 1'b0;
    set_pe    = 1'b0;
    set_fe    = 1'b0;
    brk       = 1'b0;
    frame_bad = fault_q | ~rx_s_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (warm_q[1] && rx_s_q) armed_d = 1'b1;
        if (armed_q && !rx_s_q) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == T_HALF) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_d     = '0;
            par_mis_d = 1'b0;
            fault_d   = 1'b0;
            zero_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == T_FULL) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
          if (rx_s_q) zero_d = 1'b0;
          if (bit_q == LAST_DAT) begin
            bit_d   = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == T_FULL) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
          if (rx_s_q) zero_d = 1'b0;
          // reduction gives 1 when the total one-count is odd
          par_mis_d = (PARITY_MODE == 1) ? ~(^shreg_q ^ rx_s_q) : (^shreg_q ^ rx_s_q);
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == T_FULL) begin
          cnt_d = '0;
          if (!rx_s_q) fault_d = 1'b1;
          if (bit_q == LAST_STP) begin
            state_d = S_IDLE;
            if (BRK_EN && zero_q && !rx_s_q) begin
              brk     = 1'b1;
              armed_d = 1'b0;
            end else begin
              set_pe = par_mis_q;
              set_fe = frame_bad;
              push   = ~par_mis_q & ~frame_bad;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a full FIFO still accepts a frame when the head is popped in the same cycle
  assign pop     = rd_en && (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(pop);
      pe_q    <= (pe_q  & ~err_clr) | set_pe;
      fe_q    <= (fe_q  & ~err_clr) | set_fe;
      ovr_q   <= (ovr_q & ~err_clr) | drop;
      brk_q   <= brk;
    end
  end

  assign rx_valid     = (count_q != '0);
  assign rd_data      = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count   = count_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;
  assign break_det    = brk_q;

endmodule

// File: tb/tb_uart_mike_rx_fifo.sv
// Bench for uart_mike_rx_fifo: 8 data bits, even parity, 1 stop, 10 clk/bit, 4-entry FIFO.
module tb_uart_mike_rx_fifo;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       parity_error, frame_error, overrun, break_det;

  int errors = 0;
  int checks = 0;
  int brk_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         par_flip;
    bit         stop_val;
    bit         exp_push;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;
  vec_t vecs[6];

  uart_mike_rx_fifo #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid),
    .fifo_count(fifo_count), .parity_error(parity_error), .frame_error(frame_error),
    .overrun(overrun), .err_clr(err_clr), .break_det(break_det)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (break_det === 1'b1) brk_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // rd_at/clr_at: pulse rd_en/err_clr just before that edge of the frame (edge 1 = first start-bit edge)
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_val,
                            input int rd_at, input int clr_at);
    logic [10:0] bits;
    logic [7:0]  head;
    int e;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop_val;
    e = 0;
    for (int b = 0; b < 11; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        e++;
        if (rd_at > 0) begin
          rd_en = (e == rd_at);
          if (e == rd_at && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            chk("head at pop", rd_data, head);
          end
        end
        if (clr_at > 0) err_clr = (e == clr_at);
        tick();
      end
    end
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rx      = 1'b1;
  endtask

  task automatic read_one(input string name);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    chk({name, " valid"}, rx_valid, 1);
    chk({name, " data"}, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) read_one(name);
    chk({name, " empty count"}, fifo_count, 0);
    chk({name, " empty valid"}, rx_valid, 0);
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h6E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset count", fifo_count, 0);
    chk("reset valid", rx_valid, 0);
    chk("reset data", rd_data, 0);
    chk("reset pe", parity_error, 0);
    chk("reset fe", frame_error, 0);
    chk("reset ovr", overrun, 0);
    chk("reset brk", break_det, 0);
    repeat (5) tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_push) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop_val, -1, -1);
      repeat (20) tick();
      chk($sformatf("vec%0d count", v), fifo_count, exp_q.size());
      chk($sformatf("vec%0d pe", v), parity_error, vecs[v].exp_pe);
      chk($sformatf("vec%0d fe", v), frame_error, vecs[v].exp_fe);
      drain($sformatf("vec%0d", v));
      clear_flags();
      chk($sformatf("vec%0d pe clr", v), parity_error, 0);
      chk($sformatf("vec%0d fe clr", v), frame_error, 0);
    end

    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (30) tick();
    chk("glitch count", fifo_count, 0);
    chk("glitch pe", parity_error, 0);
    chk("glitch fe", frame_error, 0);

    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty pop count", fifo_count, 0);
    chk("empty pop ovr", overrun, 0);

    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b0, 1'b1, -1, -1);
    end
    repeat (5) tick();
    chk("full count", fifo_count, 4);
    chk("full ovr", overrun, 1);
    drain("ovr");
    clear_flags();
    chk("ovr clr", overrun, 0);

    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b0, 1'b1, -1, -1);
    end
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b0, 1'b1, 108, -1);
    repeat (5) tick();
    chk("pop+push count", fifo_count, 4);
    chk("pop+push ovr", overrun, 0);
    drain("pop+push");

    send_frame(8'h3C, 1'b1, 1'b1, -1, 108);
    repeat (5) tick();
    chk("set beats clr", parity_error, 1);
    clear_flags();

    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    repeat (5) tick();
    chk("pre-rst count", fifo_count, 1);
    chk("pre-rst pe", parity_error, 1);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (40 - CPB) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst count", fifo_count, 0);
    chk("midrst valid", rx_valid, 0);
    chk("midrst data", rd_data, 0);
    chk("midrst pe", parity_error, 0);
    repeat (150) tick();
    chk("midrst no push", fifo_count, 0);
    chk("midrst no fe", frame_error, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, -1, -1);
    repeat (5) tick();
    chk("after rst count", fifo_count, 1);
    drain("after rst");

`ifdef UART_MIKE_RX_BREAK_DET_EN
    rx = 1'b0;
    repeat (200) tick();
    rx = 1'b1;
    repeat (30) tick();
    chk("break pulses", brk_cnt, 1);
    chk("break fe", frame_error, 0);
    chk("break count", fifo_count, 0);
`else
    send_frame(8'h00, 1'b0, 1'b0, -1, -1);
    repeat (20) tick();
    chk("zero frame fe", frame_error, 1);
    chk("zero frame count", fifo_count, 0);
    chk("no break", brk_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
